mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Alternating priority on conflict, with a wait-cycle timeout that aborts a stalled grant.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned AW      = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          if_valid,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [31:0]   if_rdata,
  input  logic          ls_valid,
  input  logic          ls_wren,
  input  logic [AW-1:0] ls_addr,
  input  logic [31:0]   ls_wdata,
  input  logic [3:0]    ls_bmask,
  output logic          ls_ack,
  output logic [31:0]   ls_rdata,
  output logic          err,
  output logic          mem_req,
  output logic          mem_wren,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_bmask,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_LS = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             last_ls;
  logic [CNT_W-1:0] cnt;
  logic             done;

  // Arbitration, completion/timeout detection and requester responses.
  always_comb begin
    state_next = state;
    done       = 1'b0;
    if_ack     = 1'b0;
    ls_ack     = 1'b0;
    err        = 1'b0;
    if_rdata   = '0;
    ls_rdata   = '0;
    case (state)
      IDLE: begin
        if (if_valid && (!ls_valid || last_ls)) begin
          state_next = GNT_IF;
        end else if (ls_valid) begin
          state_next = GNT_LS;
        end
      end
      GNT_IF, GNT_LS: begin
        done = mem_ack || (cnt == CNT_LAST);
        if (done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // A completion wins over a coincident timeout; an aborted grant returns zero data.
    if (!i_reset && done) begin
      err = !mem_ack;
      if (state == GNT_IF) begin
        if_ack   = 1'b1;
        if_rdata = mem_ack ? mem_rdata : '0;
      end else begin
        ls_ack   = 1'b1;
        ls_rdata = mem_ack ? mem_rdata : '0;
      end
    end
  end

  // State, priority flag, wait counter and the registered memory command.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      last_ls   <= 1'b1;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_wren  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_bmask <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && state_next == GNT_IF) begin
        mem_req   <= 1'b1;
        mem_wren  <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_bmask <= '0;
        cnt       <= '0;
        last_ls   <= 1'b0;
      end else if (state == IDLE && state_next == GNT_LS) begin
        mem_req   <= 1'b1;
        mem_wren  <= ls_wren;
        mem_addr  <= ls_addr;
        mem_wdata <= ls_wdata;
        mem_bmask <= ls_bmask;
        cnt       <= '0;
        last_ls   <= 1'b1;
      end else if (state != IDLE) begin
        if (state_next == IDLE) begin
          mem_req <= 1'b0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_mem_arbiter;

  localparam int unsigned TO = 4;
  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_valid, ls_valid, ls_wren, mem_ack;
  logic [AW-1:0] if_addr, ls_addr;
  logic [31:0]   ls_wdata, mem_rdata;
  logic [3:0]    ls_bmask;
  logic          if_ack, ls_ack, err, mem_req, mem_wren;
  logic [31:0]   if_rdata, ls_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_bmask;

  int vectors = 0;
  int fails   = 0;

  // Model: who owns the port (0 none, 1 fetch, 2 load/store), how long, and what was issued.
  int          m_owner, m_age, m_last;
  logic [31:0] m_addr, m_wdata;
  logic        m_wren;
  logic [3:0]  m_bmask;
  logic        m_if_done, m_ls_done;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(TO), .AW(AW)) dut (
    .i_clk(clk), .i_reset(rst),
    .if_valid(if_valid), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .ls_valid(ls_valid), .ls_wren(ls_wren), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_bmask(ls_bmask), .ls_ack(ls_ack), .ls_rdata(ls_rdata), .err(err),
    .mem_req(mem_req), .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_bmask(mem_bmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic finishing();
    return (m_owner != 0) && (mem_ack || m_age == int'(TO) - 1);
  endfunction

  // Combinational outputs settle, then compare everything against the model.
  task automatic settle();
    logic d;
    logic [31:0] rd;
    #3;
    d  = finishing() && !rst;
    rd = (d && mem_ack) ? mem_rdata : 32'h0;
    m_if_done = d && m_owner == 1;
    m_ls_done = d && m_owner == 2;
    chk("if_ack", 32'(if_ack), 32'(m_if_done));
    chk("ls_ack", 32'(ls_ack), 32'(m_ls_done));
    chk("err", 32'(err), 32'(d && !mem_ack));
    chk("if_rdata", if_rdata, m_if_done ? rd : 32'h0);
    chk("ls_rdata", ls_rdata, m_ls_done ? rd : 32'h0);
    chk("mem_req", 32'(mem_req), 32'(m_owner != 0));
    if (m_owner != 0) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wren", 32'(mem_wren), 32'(m_wren));
      chk("mem_bmask", 32'(mem_bmask), 32'(m_bmask));
      if (m_owner == 2) chk("mem_wdata", mem_wdata, m_wdata);
    end
  endtask

  // Clock edge: advance the model from the inputs held across the edge.
  task automatic edge_step();
    @(posedge clk);
    if (rst) begin
      m_owner = 0;
      m_last  = 2;
    end else if (m_owner != 0) begin
      if (finishing()) m_owner = 0;
      else m_age++;
    end else if (if_valid || ls_valid) begin
      m_owner = (if_valid && ls_valid) ? ((m_last == 2) ? 1 : 2) : (if_valid ? 1 : 2);
      m_last  = m_owner;
      m_age   = 0;
      if (m_owner == 1) begin
        m_addr = if_addr; m_wren = 1'b0; m_bmask = 4'h0; m_wdata = 32'h0;
      end else begin
        m_addr = ls_addr; m_wren = ls_wren; m_bmask = ls_bmask; m_wdata = ls_wdata;
      end
    end
    #1;
  endtask

  initial begin
    m_owner = 0; m_age = 0; m_last = 2;
    m_addr = '0; m_wdata = '0; m_wren = 1'b0; m_bmask = '0;
    m_if_done = 1'b0; m_ls_done = 1'b0;
    rst = 1'b1; if_valid = 1'b0; ls_valid = 1'b0; ls_wren = 1'b0; mem_ack = 1'b0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0; ls_bmask = '0; mem_rdata = '0;
    edge_step();

    // Reset state.
    settle();
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    edge_step();

    // Conflict after reset: fetch first, then the store, one idle cycle apart.
    rst = 1'b0;
    if_valid = 1'b1; if_addr = 32'h100;
    ls_valid = 1'b1; ls_wren = 1'b1; ls_addr = 32'h2000; ls_wdata = 32'hDEADBEEF; ls_bmask = 4'b0011;
    settle();
    chk("idle_mem_req", 32'(mem_req), 32'h0);
    edge_step();
    settle();
    chk("if_gnt_req", 32'(mem_req), 32'h1);
    chk("if_gnt_addr", mem_addr, 32'h100);
    chk("if_gnt_wren", 32'(mem_wren), 32'h0);
    chk("if_gnt_ls_ack", 32'(ls_ack), 32'h0);
    edge_step();
    mem_ack = 1'b1; mem_rdata = 32'h11112222;
    settle();
    chk("if_done_ack", 32'(if_ack), 32'h1);
    chk("if_done_rdata", if_rdata, 32'h11112222);
    chk("if_done_err", 32'(err), 32'h0);
    chk("if_done_ls_ack", 32'(ls_ack), 32'h0);
    edge_step();
    if_valid = 1'b0; mem_ack = 1'b0;
    settle();
    chk("gap_mem_req", 32'(mem_req), 32'h0);
    edge_step();
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("st_addr", mem_addr, 32'h2000);
      chk("st_wdata", mem_wdata, 32'hDEADBEEF);
      chk("st_bmask", 32'(mem_bmask), 32'h3);
      chk("st_wren", 32'(mem_wren), 32'h1);
      chk("st_ls_ack", 32'(ls_ack), 32'h0);
      edge_step();
    end
    mem_ack = 1'b1; mem_rdata = 32'h5;
    settle();
    chk("st_done_ack", 32'(ls_ack), 32'h1);
    chk("st_done_err", 32'(err), 32'h0);
    edge_step();

    // Load that the memory never answers: aborted in the fourth grant cycle.
    mem_ack = 1'b0; mem_rdata = 32'hFFFFFFFF;
    ls_wren = 1'b0; ls_addr = 32'h3000;
    settle();
    edge_step();
    for (int i = 1; i <= int'(TO); i++) begin
      settle();
      chk("to_ls_ack", 32'(ls_ack), (i == int'(TO)) ? 32'h1 : 32'h0);
      chk("to_err", 32'(err), (i == int'(TO)) ? 32'h1 : 32'h0);
      chk("to_ls_rdata", ls_rdata, 32'h0);
      edge_step();
    end
    ls_valid = 1'b0;
    settle();
    chk("to_after_req", 32'(mem_req), 32'h0);
    edge_step();

    // Reset while fetch holds the port, then a conflict must go to fetch again.
    if_valid = 1'b1; if_addr = 32'h400;
    settle();
    edge_step();
    settle();
    chk("rg_req", 32'(mem_req), 32'h1);
    edge_step();
    rst = 1'b1; mem_ack = 1'b1;
    settle();
    chk("rg_if_ack", 32'(if_ack), 32'h0);
    chk("rg_err", 32'(err), 32'h0);
    edge_step();
    rst = 1'b0; mem_ack = 1'b0;
    ls_valid = 1'b1; ls_wren = 1'b0; ls_addr = 32'h500;
    settle();
    chk("rg_after_req", 32'(mem_req), 32'h0);
    edge_step();
    settle();
    chk("rg_conflict_addr", mem_addr, 32'h400);
    edge_step();
    mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
    settle();
    chk("rg_if_ack2", 32'(if_ack), 32'h1);
    edge_step();
    if_valid = 1'b0; mem_ack = 1'b0;
    settle();
    edge_step();
    mem_ack = 1'b1;
    settle();
    chk("rg_ls_ack", 32'(ls_ack), 32'h1);
    edge_step();

    // Spurious memory ack with the port idle.
    ls_valid = 1'b0; mem_ack = 1'b1;
    settle();
    chk("sp_if_ack", 32'(if_ack), 32'h0);
    chk("sp_ls_ack", 32'(ls_ack), 32'h0);
    chk("sp_err", 32'(err), 32'h0);
    edge_step();

    // Random traffic: requesters hold until acked, memory answers at random.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!if_valid || m_if_done) begin
        if_valid = $urandom_range(0, 1) == 1;
        if_addr  = $urandom;
      end
      if (!ls_valid || m_ls_done) begin
        ls_valid = $urandom_range(0, 1) == 1;
        ls_wren  = $urandom_range(0, 1) == 1;
        ls_addr  = $urandom;
        ls_wdata = $urandom;
        ls_bmask = 4'($urandom_range(0, 15));
      end
      mem_ack   = ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
      settle();
      edge_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
